udp_hdr_parser: RTL

- Consumes the 16-bit AXI-stream packet stream produced by the UDP receive buffer stage.
- Extracts the 4-word UDP header (src port, dst port, length, checksum) and presents it as registered fields.
- Forwards payload words to a 16-bit downstream AXI-stream.
- Performs length checking and an optional destination-port filter; dropped or malformed packets are drained and flagged.

---
 rtl/udp_hdr_parser_if.sv | 9 +
 rtl/udp_hdr_parser.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/udp_hdr_parser_if.sv
// udp_hdr_parser_if: 16-bit AXI-stream link with valid/ready/data/last
interface udp_hdr_parser_if;
  logic        valid;
  logic        ready;
  logic [15:0] data;
  logic        last;
  modport master (output valid, data, last, input ready);
  modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/udp_hdr_parser.sv
// udp_hdr_parser: strips the 4-word UDP header, forwards payload, flags short/length/filter faults
module udp_hdr_parser #(
  parameter logic        FILTER_EN  = 1'b0,
  parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  udp_hdr_parser_if.slave         r,
  udp_hdr_parser_if.master        t,
  output logic                    hdr_valid,
  output logic [15:0]             src_port,
  output logic [15:0]             dst_port,
  output logic [15:0]             udp_len,
  output logic [15:0]             udp_csum,
  output logic                    err_short,
  output logic                    err_len,
  output logic                    drop
);
  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] rem_q, rem_d;
  logic        pend_q, pend_d;
  logic [15:0] src_port_q, src_port_d, dst_port_q, dst_port_d;
  logic [15:0] udp_len_q, udp_len_d, udp_csum_q, udp_csum_d;
  logic [15:0] t_data_q, t_data_d;
  logic        t_valid_q, t_valid_d, t_last_q, t_last_d;
  logic        hdr_valid_q, hdr_valid_d, err_short_q, err_short_d;
  logic        err_len_q, err_len_d, drop_q, drop_d;
  logic        acc;
  logic [15:0] exp_words;
  assign r.ready   = (state_q == PAYLOAD) ? (!t_valid_q || t.ready) : 1'b1;
  assign acc       = r.valid && r.ready;
  assign exp_words = (udp_len_q - 16'd7) >> 1;
  assign t.valid   = t_valid_q;
  assign t.data    = t_data_q;
  assign t.last    = t_last_q;
  assign hdr_valid = hdr_valid_q;
  assign src_port  = src_port_q;
  assign dst_port  = dst_port_q;
  assign udp_len   = udp_len_q;
  assign udp_csum  = udp_csum_q;
  assign err_short = err_short_q;
  assign err_len   = err_len_q;
  assign drop      = drop_q;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    pend_d      = pend_q;
    src_port_d  = src_port_q;
    dst_port_d  = dst_port_q;
    udp_len_d   = udp_len_q;
    udp_csum_d  = udp_csum_q;
    t_data_d    = t_data_q;
    t_valid_d   = t_valid_q && !t.ready;
    t_last_d    = t_last_q && t_valid_d;
    hdr_valid_d = 1'b0;
    err_short_d = 1'b0;
    err_len_d   = 1'b0;
    drop_d      = 1'b0;
    if (acc && state_q == HDR) begin
      src_port_d  = (idx_q == 2'd0) ? r.data : src_port_q;
      dst_port_d  = (idx_q == 2'd1) ? r.data : dst_port_q;
      udp_len_d   = (idx_q == 2'd2) ? r.data : udp_len_q;
      udp_csum_d  = (idx_q == 2'd3) ? r.data : udp_csum_q;
      idx_d       = (r.last || idx_q == 2'd3) ? 2'd0 : idx_q + 2'd1;
      err_short_d = r.last && idx_q != 2'd3;
      // udp_len was captured on the previous beat, so the verdict is ready as beat 3 lands
      if (idx_q == 2'd3) begin
        hdr_valid_d = 1'b1;
        pend_d      = 1'b0;
        if (r.last)
          err_len_d = exp_words != 16'd0;
        else if (udp_len_q < 16'd8) begin
          err_len_d = 1'b1;
          state_d   = DROP;
        end else if (FILTER_EN && dst_port_q != LOCAL_PORT) begin
          drop_d  = 1'b1;
          state_d = DROP;
        end else if (exp_words == 16'd0) begin
          err_len_d = 1'b1;
          state_d   = DROP;
        end else begin
          state_d = PAYLOAD;
          rem_d   = exp_words;
        end
      end
    end else if (acc && state_q == PAYLOAD) begin
      t_valid_d = 1'b1;
      t_data_d  = r.data;
      t_last_d  = (rem_q == 16'd1) || r.last;
      rem_d     = rem_q - 16'd1;
      if (r.last) begin
        state_d   = HDR;
        err_len_d = rem_q != 16'd1;
      end else if (rem_q == 16'd1) begin
        state_d = DROP;
        pend_d  = 1'b1;
      end
    end else if (acc && state_q == DROP && r.last) begin
      // an overlong packet reports its length fault only once the tail is drained
      state_d   = HDR;
      err_len_d = pend_q;
      pend_d    = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HDR;
      idx_q       <= 2'd0;
      rem_q       <= 16'd0;
      pend_q      <= 1'b0;
      src_port_q  <= 16'd0;
      dst_port_q  <= 16'd0;
      udp_len_q   <= 16'd0;
      udp_csum_q  <= 16'd0;
      t_data_q    <= 16'd0;
      t_valid_q   <= 1'b0;
      t_last_q    <= 1'b0;
      hdr_valid_q <= 1'b0;
      err_short_q <= 1'b0;
      err_len_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      pend_q      <= pend_d;
      src_port_q  <= src_port_d;
      dst_port_q  <= dst_port_d;
      udp_len_q   <= udp_len_d;
      udp_csum_q  <= udp_csum_d;
      t_data_q    <= t_data_d;
      t_valid_q   <= t_valid_d;
      t_last_q    <= t_last_d;
      hdr_valid_q <= hdr_valid_d;
      err_short_q <= err_short_d;
      err_len_q   <= err_len_d;
      drop_q      <= drop_d;
    end
  end
endmodule
